// File: rtl/vga_timing_ctrl.sv
// 640x480@60 VGA raster timing generator: free-running h/v counters with combinational sync,
// blanking, active-area address and blank-gated RGB decode.
module vga_timing_ctrl #(
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] vga_data,
  output logic [9:0]  h_addr,
  output logic [9:0]  v_addr,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_clk
);

  // Both line and frame totals must stay within 1023 so the 10-bit counters never overflow.
  localparam logic [9:0] HSyncEnd  = 10'(H_SYNC);
  localparam logic [9:0] HActStart = 10'(H_SYNC + H_BP);
  localparam logic [9:0] HActEnd   = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] HLast     = 10'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam logic [9:0] VSyncEnd  = 10'(V_SYNC);
  localparam logic [9:0] VActStart = 10'(V_SYNC + V_BP);
  localparam logic [9:0] VActEnd   = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0] VLast     = 10'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       h_active, v_active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == HLast) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 10'd1;
    end
  end

  always_comb begin
    h_active    = (h_cnt_q >= HActStart) && (h_cnt_q < HActEnd);
    v_active    = (v_cnt_q >= VActStart) && (v_cnt_q < VActEnd);
    vga_hs      = (h_cnt_q >= HSyncEnd);
    vga_vs      = (v_cnt_q >= VSyncEnd);
    vga_blank_n = h_active & v_active;
    h_addr      = h_active ? (h_cnt_q - HActStart) : '0;
    v_addr      = v_active ? (v_cnt_q - VActStart) : '0;
    vga_r       = 8'h00;
    vga_g       = 8'h00;
    vga_b       = 8'h00;
    // Frame store is asynchronous-read, so the addressed pixel is forwarded in the same cycle.
    if (vga_blank_n) begin
      vga_r = vga_data[23:16];
      vga_g = vga_data[15:8];
      vga_b = vga_data[7:0];
    end
  end

  assign vga_clk = clk;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl: a default 640x480 instance plus a shrunken-timing
// instance so full-frame wrap and per-frame counts fit in a short run.
module tb_vga_timing_ctrl;

  logic        clk;
  logic        rst;
  logic        pass_mode;
  logic [23:0] data_const;
  logic [23:0] vga_data;
  logic [9:0]  h_addr, v_addr;
  logic        vga_hs, vga_vs, vga_blank_n, vga_clk;
  logic [7:0]  vga_r, vga_g, vga_b;

  logic [23:0] s_data;
  logic [9:0]  s_h_addr, s_v_addr;
  logic        s_hs, s_vs, s_blank_n, s_clk;
  logic [7:0]  s_r, s_g, s_b;

  int checks;
  int failures;
  int cyc;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       bl;
    logic [9:0] ha;
    logic [9:0] va;
  } exp_t;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Frame-store stand-ins: asynchronous read keyed on the DUT addresses.
  assign vga_data = pass_mode ? {h_addr[7:0], v_addr[7:0], 8'h5A} : data_const;
  assign s_data   = {s_h_addr[7:0], s_v_addr[7:0], 8'h5A};

  vga_timing_ctrl u_dut (
    .clk        (clk),
    .rst        (rst),
    .vga_data   (vga_data),
    .h_addr     (h_addr),
    .v_addr     (v_addr),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .vga_blank_n(vga_blank_n),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .vga_clk    (vga_clk)
  );

  // h: sync 0..3, active 7..14, total 17; v: sync 0..1, active 5..9, total 12; frame 204.
  vga_timing_ctrl #(
    .H_SYNC  (4),
    .H_BP    (3),
    .H_ACTIVE(8),
    .H_FP    (2),
    .V_SYNC  (2),
    .V_BP    (3),
    .V_ACTIVE(5),
    .V_FP    (2)
  ) u_small (
    .clk        (clk),
    .rst        (rst),
    .vga_data   (s_data),
    .h_addr     (s_h_addr),
    .v_addr     (s_v_addr),
    .vga_hs     (s_hs),
    .vga_vs     (s_vs),
    .vga_blank_n(s_blank_n),
    .vga_r      (s_r),
    .vga_g      (s_g),
    .vga_b      (s_b),
    .vga_clk    (s_clk)
  );

  function automatic exp_t model(input int c, input int hsw, input int hbp, input int hact,
                                 input int htot, input int vsw, input int vbp, input int vact,
                                 input int vtot);
    exp_t e;
    int   hc, vc;
    bit   ha, va;
    hc   = c % htot;
    vc   = (c / htot) % vtot;
    ha   = (hc >= hsw + hbp) && (hc < hsw + hbp + hact);
    va   = (vc >= vsw + vbp) && (vc < vsw + vbp + vact);
    e.hs = (hc >= hsw);
    e.vs = (vc >= vsw);
    e.bl = ha && va;
    e.ha = ha ? 10'(hc - hsw - hbp) : 10'd0;
    e.va = va ? 10'(vc - vsw - vbp) : 10'd0;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    pass_mode  = 1'b0;
    data_const = 24'hFFFFFF;
    #23;
    checks++;
    if ({vga_hs, vga_vs, vga_blank_n} !== 3'b000) begin
      failures++;
      $display("FAIL reset_sync got hs/vs/blank=%b required=000", {vga_hs, vga_vs, vga_blank_n});
    end
    checks++;
    if ({h_addr, v_addr} !== 20'd0) begin
      failures++;
      $display("FAIL reset_addr got h=%0d v=%0d required 0/0", h_addr, v_addr);
    end
    checks++;
    if ({vga_r, vga_g, vga_b} !== 24'h0) begin
      failures++;
      $display("FAIL reset_rgb got=%h required=000000", {vga_r, vga_g, vga_b});
    end
    checks++;
    if ({s_hs, s_vs, s_blank_n} !== 3'b000) begin
      failures++;
      $display("FAIL reset_small got hs/vs/blank=%b required=000", {s_hs, s_vs, s_blank_n});
    end
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_hsync();
    int   lows = 0, falls = 0, vlows = 0, bad = 0;
    logic prev;
    exp_t e;
    prev = vga_hs;
    for (int i = 0; i < 2400; i++) begin
      e = model(cyc, 96, 48, 640, 800, 2, 33, 480, 525);
      if (vga_hs !== e.hs || vga_vs !== e.vs) bad++;
      if (!vga_hs) lows++;
      if (prev && !vga_hs) falls++;
      if (!vga_vs) vlows++;
      prev = vga_hs;
      step();
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL hsync_shape got %0d bad cycles required 0", bad);
    end
    checks++;
    if (lows !== 288) begin
      failures++;
      $display("FAIL hsync_low_count got=%0d required=288", lows);
    end
    checks++;
    if (falls !== 2) begin
      failures++;
      $display("FAIL hsync_period got %0d falling edges required 2", falls);
    end
    checks++;
    if (vlows !== 1600) begin
      failures++;
      $display("FAIL vsync_low_count got=%0d required=1600", vlows);
    end
  endtask

  task automatic test_active_window();
    int   bad = 0;
    exp_t e;
    data_const = 24'hFF0000;
    while (cyc < 35 * 800 + 144) begin
      e = model(cyc, 96, 48, 640, 800, 2, 33, 480, 525);
      if ({vga_hs, vga_vs, vga_blank_n, h_addr, v_addr} !== e) bad++;
      if ({vga_r, vga_g, vga_b} !== (e.bl ? 24'hFF0000 : 24'h0)) bad++;
      step();
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL pre_active_decode got %0d bad cycles required 0", bad);
    end
    checks++;
    if ({vga_blank_n, h_addr, v_addr} !== {1'b1, 10'd0, 10'd0}) begin
      failures++;
      $display("FAIL first_pixel got blank=%b h=%0d v=%0d required 1/0/0",
               vga_blank_n, h_addr, v_addr);
    end
    checks++;
    if ({vga_r, vga_g, vga_b} !== 24'hFF0000) begin
      failures++;
      $display("FAIL first_pixel_rgb got=%h required=ff0000", {vga_r, vga_g, vga_b});
    end
    while (cyc < 35 * 800 + 783) step();
    checks++;
    if ({vga_blank_n, h_addr, v_addr, vga_r} !== {1'b1, 10'd639, 10'd0, 8'hFF}) begin
      failures++;
      $display("FAIL last_pixel_line got blank=%b h=%0d v=%0d r=%h required 1/639/0/ff",
               vga_blank_n, h_addr, v_addr, vga_r);
    end
    step();
    checks++;
    if ({vga_blank_n, h_addr, vga_r, vga_g, vga_b} !== 35'd0) begin
      failures++;
      $display("FAIL front_porch got blank=%b h=%0d rgb=%h required 0/0/000000",
               vga_blank_n, h_addr, {vga_r, vga_g, vga_b});
    end
  endtask

  task automatic test_passthrough();
    int   bad = 0, act = 0;
    exp_t e;
    pass_mode = 1'b1;
    while (cyc < 37 * 800) begin
      e = model(cyc, 96, 48, 640, 800, 2, 33, 480, 525);
      if ({vga_r, vga_g, vga_b} !== (e.bl ? {e.ha[7:0], e.va[7:0], 8'h5A} : 24'h0)) bad++;
      if (vga_blank_n) act++;
      if (cyc == 36 * 800 + 444) begin
        checks++;
        if ({vga_r, vga_g, vga_b} !== 24'h2C015A) begin
          failures++;
          $display("FAIL pass_pixel_300_1 got=%h required=2c015a", {vga_r, vga_g, vga_b});
        end
      end
      step();
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL pass_through got %0d bad cycles required 0", bad);
    end
    checks++;
    if (act !== 640) begin
      failures++;
      $display("FAIL active_per_line got=%0d required=640", act);
    end
  endtask

  task automatic test_blank_gating();
    int nz = 0, leak = 0;
    pass_mode  = 1'b0;
    data_const = 24'hFFFFFF;
    while (cyc < 38 * 800) begin
      if ({vga_r, vga_g, vga_b} !== 24'h0) begin
        nz++;
        if (!vga_blank_n) leak++;
      end
      step();
    end
    checks++;
    if (nz !== 640) begin
      failures++;
      $display("FAIL gated_nonzero got=%0d required=640", nz);
    end
    checks++;
    if (leak !== 0) begin
      failures++;
      $display("FAIL gated_leak got=%0d required=0", leak);
    end
  endtask

  task automatic test_small_frames();
    int   bad = 0, vlows = 0, act = 0, wraps = 0, lastpix = 0;
    exp_t e;
    for (int i = 0; i < 408; i++) begin
      e = model(cyc, 4, 3, 8, 17, 2, 3, 5, 12);
      if ({s_hs, s_vs, s_blank_n, s_h_addr, s_v_addr} !== e) bad++;
      if ({s_r, s_g, s_b} !== (e.bl ? {e.ha[7:0], e.va[7:0], 8'h5A} : 24'h0)) bad++;
      if (!s_vs) vlows++;
      if (s_blank_n) act++;
      if (s_blank_n && s_h_addr == 10'd7 && s_v_addr == 10'd4) lastpix++;
      if (cyc % 204 == 0) begin
        wraps++;
        if ({s_hs, s_vs} !== 2'b00) bad++;
      end
      step();
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL small_decode got %0d bad cycles required 0", bad);
    end
    checks++;
    if (vlows !== 68 || wraps !== 2) begin
      failures++;
      $display("FAIL small_vsync got lows=%0d wraps=%0d required 68/2", vlows, wraps);
    end
    checks++;
    if (act !== 80 || lastpix !== 2) begin
      failures++;
      $display("FAIL small_active got act=%0d last=%0d required 80/2", act, lastpix);
    end
  endtask

  task automatic test_midline_reset();
    while (cyc < 39 * 800 + 400) step();
    checks++;
    if ({vga_blank_n, vga_r, vga_g, vga_b} !== {1'b1, 24'hFFFFFF}) begin
      failures++;
      $display("FAIL midline_pre got blank=%b rgb=%h required 1/ffffff",
               vga_blank_n, {vga_r, vga_g, vga_b});
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({vga_hs, vga_vs, vga_blank_n, h_addr, v_addr, vga_r, vga_g, vga_b} !== 47'd0) begin
      failures++;
      $display("FAIL midline_async got hs=%b vs=%b blank=%b h=%0d v=%0d rgb=%h required all 0",
               vga_hs, vga_vs, vga_blank_n, h_addr, v_addr, {vga_r, vga_g, vga_b});
    end
    checks++;
    if (vga_clk !== 1'b1) begin
      failures++;
      $display("FAIL vga_clk_high got=%b required=1", vga_clk);
    end
    @(negedge clk);
    checks++;
    if (vga_clk !== 1'b0) begin
      failures++;
      $display("FAIL vga_clk_low got=%b required=0", vga_clk);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    while (cyc < 95) step();
    checks++;
    if (vga_hs !== 1'b0) begin
      failures++;
      $display("FAIL restart_hs_95 got=%b required=0", vga_hs);
    end
    step();
    checks++;
    if (vga_hs !== 1'b1) begin
      failures++;
      $display("FAIL restart_hs_96 got=%b required=1", vga_hs);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    test_reset();
    test_hsync();
    test_active_window();
    test_passthrough();
    test_blank_gating();
    test_small_frames();
    test_midline_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
